// File: rtl/neuron_mac.sv
// neuron_mac: streaming multiply-accumulate for one neuron.
// Pairs each input sample with its weight from a 1-cycle-latency memory,
// accumulates saturated signed products, then adds the bias and emits one
// registered sum per input vector.
module neuron_mac #(
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [dataWidth-1:0]   myinput,
    input  logic                          myinputValid,
    input  logic signed [2*dataWidth-1:0] bias,
    output logic                          ren,
    output logic [addressWidth-1:0]       radd,
    input  logic signed [dataWidth-1:0]   wout,
    output logic signed [2*dataWidth-1:0] sum,
    output logic                          outvalid
);

    localparam int AccWidth = 2 * dataWidth;
    localparam logic [addressWidth-1:0] LastAddr = addressWidth'(numWeight - 1);
    localparam logic signed [AccWidth-1:0] SatMax = {1'b0, {(AccWidth-1){1'b1}}};
    localparam logic signed [AccWidth-1:0] SatMin = {1'b1, {(AccWidth-1){1'b0}}};

    logic signed [dataWidth-1:0] in_d;
    logic signed [AccWidth-1:0]  mul_r;
    logic signed [AccWidth-1:0]  acc;
    logic                        v1, v2, l1, l2, bias_pend;

    // Signed add that clamps to the representable range on overflow.
    function automatic logic signed [AccWidth-1:0] sat_add(
        input logic signed [AccWidth-1:0] a,
        input logic signed [AccWidth-1:0] b
    );
        logic signed [AccWidth-1:0] s;
        // NOTE: blocking assignments are correct here; a function is pure
        // combinational scratch work, unlike the clocked state below.
        s = a + b;
        if ((a[AccWidth-1] == b[AccWidth-1]) && (s[AccWidth-1] != a[AccWidth-1]))
            s = a[AccWidth-1] ? SatMin : SatMax;
        return s;
    endfunction

    // Read request goes out in the same cycle the sample is accepted.
    assign ren = myinputValid & ~rst;

    // Address counter and pipeline control flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            radd      <= '0;
            v1        <= 1'b0;
            l1        <= 1'b0;
            v2        <= 1'b0;
            l2        <= 1'b0;
            bias_pend <= 1'b0;
        end else begin
            if (myinputValid)
                radd <= (radd == LastAddr) ? '0 : radd + 1'b1;
            v1        <= myinputValid;
            l1        <= myinputValid && (radd == LastAddr);
            v2        <= v1;
            l2        <= l1;
            bias_pend <= v2 & l2;
        end
    end

    // NOTE: in_d and mul_r carry no reset; they are only consumed when the
    // matching v1/v2 flag is set, and those flags are reset.
    // Operand capture and product register.
    always_ff @(posedge clk) begin
        in_d  <= myinput;
        mul_r <= in_d * wout;
    end

    // Accumulator, bias add and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            sum      <= '0;
            outvalid <= 1'b0;
        end else if (bias_pend) begin
            sum      <= sat_add(acc, bias);
            outvalid <= 1'b1;
            // The first product of the next vector may arrive on this very edge.
            acc      <= v2 ? mul_r : '0;
        end else begin
            outvalid <= 1'b0;
            if (v2)
                acc <= sat_add(acc, mul_r);
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed bench for neuron_mac with a 3-weight vector.
// Expected sums and their due cycles are queued as vectors are driven and
// popped when outvalid appears.
module tb_neuron_mac;

    localparam int NW = 3;
    localparam int AW = 2;
    localparam int DW = 16;

    typedef struct {
        logic [2*DW-1:0] sum;
        int              cyc;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic signed [DW-1:0]     myinput;
    logic                     myinputValid;
    logic signed [2*DW-1:0]   bias;
    logic                     ren;
    logic [AW-1:0]            radd;
    logic signed [DW-1:0]     wout;
    logic signed [2*DW-1:0]   sum;
    logic                     outvalid;

    logic signed [DW-1:0]     mem [0:(1<<AW)-1];
    exp_t                     sb[$];
    int                       cyc = 0;
    int                       exp_radd = 0;
    int                       checks = 0;
    int                       errors = 0;

    neuron_mac #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW)) dut (
        .clk(clk), .rst(rst), .myinput(myinput), .myinputValid(myinputValid),
        .bias(bias), .ren(ren), .radd(radd), .wout(wout), .sum(sum),
        .outvalid(outvalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Weight memory with registered read, one cycle after ren.
    always @(posedge clk) if (ren) wout <= mem[radd];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_weights(input logic signed [DW-1:0] w0, w1, w2);
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = w2;
        mem[3] = '0;
    endtask

    // Present one sample for one cycle; called 1 time unit after a rising edge.
    task automatic feed(input string tag, input logic signed [DW-1:0] x,
                        input bit last, input logic [2*DW-1:0] exp_sum);
        myinput      = x;
        myinputValid = 1'b1;
        #1;
        check({tag, "_ren"}, 32'(ren), 32'd1);
        check({tag, "_radd"}, 32'(radd), 32'(exp_radd));
        if (last) sb.push_back('{exp_sum, cyc + 4});
        exp_radd = (exp_radd == NW - 1) ? 0 : exp_radd + 1;
        @(posedge clk);
        #1;
        myinputValid = 1'b0;
    endtask

    task automatic idle_cycle(input string tag);
        #1;
        check({tag, "_gap_ren"}, 32'(ren), 32'd0);
        check({tag, "_gap_radd"}, 32'(radd), 32'(exp_radd));
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the next outvalid pulse and score it.
    task automatic expect_out(input string tag);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!outvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!outvalid || sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_out: observed outvalid=%b queued=%0d expected a pulse", tag, outvalid, sb.size());
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check({tag, "_sum"}, sum, e.sum);
        check({tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
        @(negedge clk);
        check({tag, "_pulse_end"}, 32'(outvalid), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        myinput      = '0;
        myinputValid = 1'b0;
        bias         = '0;
        set_weights(16'sd2, 16'sd3, -16'sd1);
        step();
        step();
        check("rst_radd", 32'(radd), 32'd0);
        check("rst_outvalid", 32'(outvalid), 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_ren", 32'(ren), 32'd0);
        rst = 1'b0;
        step();

        // Basic vector: 1*2 + 2*3 + 3*(-1) + 4 = 9.
        bias = 32'sd4;
        feed("v1", 16'sd1, 1'b0, '0);
        feed("v1", 16'sd2, 1'b0, '0);
        feed("v1", 16'sd3, 1'b1, 32'd9);
        check("v1_radd_wrap", 32'(radd), 32'd0);
        expect_out("v1");

        // Same vector with one-cycle gaps.
        feed("gap", 16'sd1, 1'b0, '0);
        idle_cycle("gap0");
        feed("gap", 16'sd2, 1'b0, '0);
        idle_cycle("gap1");
        feed("gap", 16'sd3, 1'b1, 32'd9);
        expect_out("gap");

        // Back-to-back vectors, bias 0: 5 then -4, pulses 3 cycles apart.
        bias = '0;
        feed("b2b", 16'sd1, 1'b0, '0);
        feed("b2b", 16'sd2, 1'b0, '0);
        feed("b2b", 16'sd3, 1'b1, 32'd5);
        feed("b2b", -16'sd1, 1'b0, '0);
        feed("b2b", -16'sd1, 1'b0, '0);
        feed("b2b", -16'sd1, 1'b1, 32'hFFFF_FFFC);
        expect_out("b2b_a");
        expect_out("b2b_b");

        // Positive saturation.
        set_weights(16'sh7FFF, 16'sh7FFF, 16'sh7FFF);
        for (int i = 0; i < NW; i++)
            feed("psat", 16'sh7FFF, i == NW - 1, 32'h7FFF_FFFF);
        expect_out("psat");

        // Negative saturation.
        for (int i = 0; i < NW; i++)
            feed("nsat", 16'sh8000, i == NW - 1, 32'h8000_0000);
        expect_out("nsat");

        // Bias saturation: products sum to 0x7FFF_FFF0, bias 0x100.
        set_weights(16'sh8000, 16'sh8001, 16'sd1);
        bias = 32'sh100;
        feed("bsat", 16'sh8000, 1'b0, '0);
        feed("bsat", 16'sh8000, 1'b0, '0);
        feed("bsat", 16'sd32752, 1'b1, 32'h7FFF_FFFF);
        expect_out("bsat");

        // Asynchronous reset after two of three inputs.
        set_weights(16'sd2, 16'sd3, -16'sd1);
        bias = 32'sd4;
        feed("prst", 16'sd1, 1'b0, '0);
        feed("prst", 16'sd2, 1'b0, '0);
        #2;
        rst          = 1'b1;
        myinputValid = 1'b1;
        #1;
        check("arst_radd", 32'(radd), 32'd0);
        check("arst_ren", 32'(ren), 32'd0);
        check("arst_sum", sum, 32'd0);
        myinputValid = 1'b0;
        exp_radd     = 0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("arst_no_out", 32'(outvalid), 32'd0);
            step();
        end
        feed("post", 16'sd1, 1'b0, '0);
        feed("post", 16'sd2, 1'b0, '0);
        feed("post", 16'sd3, 1'b1, 32'd9);
        expect_out("post");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
